// File: rtl/ocdm_sched_pkg.sv
// ---------------------------------------------------------------------------
// ocdm_sched_pkg
// Shared definitions for the OCDM frame scheduler:
//   MODUL_WIDTH - width of the modulation code carried with each frame
//   state_t     - scheduler FSM states (IDLE: arbitrating, BUSY: frame open)
//   src_t       - index of an input source (0 or 1)
// ---------------------------------------------------------------------------
package ocdm_sched_pkg;

    localparam int MODUL_WIDTH = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    typedef logic src_t;

endpackage

// File: rtl/ocdm_rr_arb2.sv
// ---------------------------------------------------------------------------
// ocdm_rr_arb2
// Two-way round-robin decision, purely combinational.
// Ports:
//   req0, req1 : in  - request from source 0 / source 1
//   last_gnt   : in  - source granted most recently
//   gnt_vld    : out - at least one request present
//   gnt        : out - chosen source index (meaningful when gnt_vld=1)
// ---------------------------------------------------------------------------
module ocdm_rr_arb2
    import ocdm_sched_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_gnt,
    output logic gnt_vld,
    output logic gnt
);

    src_t choice;

    always_comb begin
        choice = 1'b0;
        if (req0 && req1) begin
            // Contention: favour whoever did not get the previous frame.
            choice = ~last_gnt;
        end else if (req1) begin
            choice = 1'b1;
        end
    end

    assign gnt_vld = req0 | req1;
    assign gnt     = choice;

endmodule

// File: rtl/ocdm_frame_scheduler.sv
// ---------------------------------------------------------------------------
// ocdm_frame_scheduler
// Frame-level two-input scheduler. Whole frames (tfirst..tlast) from s0 or
// s1 are forwarded to the master port with zero latency; the source is
// chosen round-robin while idle and held until the frame's tlast transfer.
// A modulation code is latched per frame from a pending config register.
//
// Ports:
//   clk, reset              - clock, asynchronous active-high reset
//   cfg_tvalid/modulation   - config write into the pending register
//   s0_*, s1_*              - slave streams (tvalid/tfirst/tlast/bus, tready)
//   m_*                     - master stream (tvalid/tfirst/tlast/bus, tready)
//   m_modulation            - modulation active for the current frame
//   m_src                   - granted source index
//   err_orphan              - sticky: a beat arrived outside any frame
//   frame_cnt0/frame_cnt1   - completed-frame counters per source
//                             (only with OCDM_SCHED_FRAME_CNT_EN defined)
//
// Build option: `define OCDM_SCHED_FRAME_CNT_EN adds the frame counters.
// ---------------------------------------------------------------------------
module ocdm_frame_scheduler
    import ocdm_sched_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int LANE       = 2
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                cfg_tvalid,
    input  logic [MODUL_WIDTH-1:0]              cfg_modulation,
    input  logic                                s0_tvalid,
    input  logic                                s0_tfirst,
    input  logic                                s0_tlast,
    input  logic signed [LANE*DATA_WIDTH-1:0]   s0_bus,
    output logic                                s0_tready,
    input  logic                                s1_tvalid,
    input  logic                                s1_tfirst,
    input  logic                                s1_tlast,
    input  logic signed [LANE*DATA_WIDTH-1:0]   s1_bus,
    output logic                                s1_tready,
    output logic                                m_tvalid,
    output logic                                m_tfirst,
    output logic                                m_tlast,
    output logic signed [LANE*DATA_WIDTH-1:0]   m_bus,
    input  logic                                m_tready,
    output logic [MODUL_WIDTH-1:0]              m_modulation,
    output logic                                m_src,
`ifdef OCDM_SCHED_FRAME_CNT_EN
    output logic [15:0]                         frame_cnt0,
    output logic [15:0]                         frame_cnt1,
`endif
    output logic                                err_orphan
);

    state_t                 state_q, state_d;
    src_t                   src_q;
    src_t                   last_q;
    logic [MODUL_WIDTH-1:0] pend_q;
    logic [MODUL_WIDTH-1:0] act_q;
    logic                   orphan_q;

    logic req0, req1;
    logic gnt_vld;
    src_t gnt;
    logic grant_en;
    logic frame_done;
    logic orphan_hit;

    // Only a beat that opens a frame may request; anything else seen while
    // idle is an orphan and gets swallowed instead.
    assign req0 = s0_tvalid & s0_tfirst;
    assign req1 = s1_tvalid & s1_tfirst;

    ocdm_rr_arb2 u_arb (
        .req0     (req0),
        .req1     (req1),
        .last_gnt (last_q),
        .gnt_vld  (gnt_vld),
        .gnt      (gnt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        m_tvalid   = 1'b0;
        m_tfirst   = 1'b0;
        m_tlast    = 1'b0;
        m_bus      = '0;
        s0_tready  = 1'b0;
        s1_tready  = 1'b0;
        grant_en   = 1'b0;
        frame_done = 1'b0;
        orphan_hit = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Reset is level-sensitive here too so no tready leaks out
                // while the registers are held in reset.
                if (!reset) begin
                    s0_tready  = s0_tvalid & ~s0_tfirst;
                    s1_tready  = s1_tvalid & ~s1_tfirst;
                    orphan_hit = s0_tready | s1_tready;
                    if (gnt_vld) begin
                        grant_en = 1'b1;
                        state_d  = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (src_q == 1'b0) begin
                    m_tvalid  = s0_tvalid;
                    m_tfirst  = s0_tfirst;
                    m_tlast   = s0_tlast;
                    m_bus     = s0_bus;
                    s0_tready = m_tready;
                end else begin
                    m_tvalid  = s1_tvalid;
                    m_tfirst  = s1_tfirst;
                    m_tlast   = s1_tlast;
                    m_bus     = s1_bus;
                    s1_tready = m_tready;
                end
                // A mid-frame tfirst is just data; only tlast closes.
                if (m_tvalid && m_tready && m_tlast) begin
                    frame_done = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_q    <= 1'b0;
            last_q   <= 1'b1;
            pend_q   <= '0;
            act_q    <= '0;
            orphan_q <= 1'b0;
        end else begin
            if (cfg_tvalid) begin
                pend_q <= cfg_modulation;
            end
            if (grant_en) begin
                src_q <= gnt;
                // A write landing on the grant cycle bypasses pending.
                act_q <= cfg_tvalid ? cfg_modulation : pend_q;
            end
            if (frame_done) begin
                last_q <= src_q;
            end
            if (orphan_hit) begin
                orphan_q <= 1'b1;
            end
        end
    end

`ifdef OCDM_SCHED_FRAME_CNT_EN
    logic [15:0] cnt0_q, cnt1_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else if (frame_done) begin
            if (src_q == 1'b0) begin
                cnt0_q <= cnt0_q + 16'd1;
            end else begin
                cnt1_q <= cnt1_q + 16'd1;
            end
        end
    end

    assign frame_cnt0 = cnt0_q;
    assign frame_cnt1 = cnt1_q;
`endif

    assign m_modulation = act_q;
    assign m_src        = src_q;
    assign err_orphan   = orphan_q;

endmodule

// File: tb/tb_ocdm_frame_scheduler.sv
// ---------------------------------------------------------------------------
// tb_ocdm_frame_scheduler
// Directed bench for ocdm_frame_scheduler. Sources are fed from beat queues;
// a frame-level model (who owns the output, who won last, pending/active
// modulation, orphan flag) predicts every output on every cycle, and the
// forwarded beat log is compared against hand-written expected sequences.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ocdm_frame_scheduler;

    localparam int DW = 16;
    localparam int LN = 2;
    localparam int BW = DW * LN;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset;
    logic                 cfg_tvalid;
    logic [2:0]           cfg_modulation;
    logic                 s0_tvalid, s0_tfirst, s0_tlast, s0_tready;
    logic signed [BW-1:0] s0_bus;
    logic                 s1_tvalid, s1_tfirst, s1_tlast, s1_tready;
    logic signed [BW-1:0] s1_bus;
    logic                 m_tvalid, m_tfirst, m_tlast, m_tready;
    logic signed [BW-1:0] m_bus;
    logic [2:0]           m_modulation;
    logic                 m_src;
    logic                 err_orphan;
`ifdef OCDM_SCHED_FRAME_CNT_EN
    logic [15:0]          frame_cnt0, frame_cnt1;
`endif

    ocdm_frame_scheduler #(.DATA_WIDTH(DW), .LANE(LN)) dut (
        .clk            (clk),
        .reset          (reset),
        .cfg_tvalid     (cfg_tvalid),
        .cfg_modulation (cfg_modulation),
        .s0_tvalid      (s0_tvalid),
        .s0_tfirst      (s0_tfirst),
        .s0_tlast       (s0_tlast),
        .s0_bus         (s0_bus),
        .s0_tready      (s0_tready),
        .s1_tvalid      (s1_tvalid),
        .s1_tfirst      (s1_tfirst),
        .s1_tlast       (s1_tlast),
        .s1_bus         (s1_bus),
        .s1_tready      (s1_tready),
        .m_tvalid       (m_tvalid),
        .m_tfirst       (m_tfirst),
        .m_tlast        (m_tlast),
        .m_bus          (m_bus),
        .m_tready       (m_tready),
        .m_modulation   (m_modulation),
        .m_src          (m_src),
`ifdef OCDM_SCHED_FRAME_CNT_EN
        .frame_cnt0     (frame_cnt0),
        .frame_cnt1     (frame_cnt1),
`endif
        .err_orphan     (err_orphan)
    );

    typedef struct {
        logic          first;
        logic          last;
        logic [BW-1:0] data;
    } beat_t;

    typedef struct {
        logic [BW-1:0] data;
        logic          src;
        logic [2:0]    mod;
    } obs_t;

    beat_t q0[$];
    beat_t q1[$];
    obs_t  olog[$];

    int n_chk  = 0;
    int n_fail = 0;
    bit tog    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    int         mo_owner = -1;     // -1: no frame open, else source index
    logic       mo_last  = 1'b1;
    logic [2:0] mo_pend  = 3'd0;
    logic [2:0] mo_act   = 3'd0;
    logic       mo_orph  = 1'b0;
    logic [15:0] mo_cnt0 = 16'd0;
    logic [15:0] mo_cnt1 = 16'd0;

    int          nx_owner;
    logic        nx_last;
    logic [2:0]  nx_pend, nx_act;
    logic        nx_orph;
    logic [15:0] nx_cnt0, nx_cnt1;

    always @(negedge clk) begin
        logic r0, r1, ev, et, ef, el;
        logic [BW-1:0] eb;
        nx_owner = mo_owner; nx_last = mo_last; nx_pend = mo_pend;
        nx_act   = mo_act;   nx_orph = mo_orph;
        nx_cnt0  = mo_cnt0;  nx_cnt1 = mo_cnt1;
        if (reset) begin
            check("rst_s0_tready", s0_tready, 0);
            check("rst_s1_tready", s1_tready, 0);
            check("rst_m_tvalid", m_tvalid, 0);
            check("rst_err_orphan", err_orphan, 0);
            check("rst_m_modulation", m_modulation, 0);
            nx_owner = -1; nx_last = 1'b1; nx_pend = 0; nx_act = 0;
            nx_orph = 0; nx_cnt0 = 0; nx_cnt1 = 0;
        end else begin
            check("mdl_m_modulation", m_modulation, mo_act);
            check("mdl_err_orphan", err_orphan, mo_orph);
`ifdef OCDM_SCHED_FRAME_CNT_EN
            check("mdl_frame_cnt0", frame_cnt0, mo_cnt0);
            check("mdl_frame_cnt1", frame_cnt1, mo_cnt1);
`endif
            if (mo_owner < 0) begin
                check("idle_m_tvalid", m_tvalid, 0);
                check("idle_s0_tready", s0_tready, s0_tvalid & ~s0_tfirst);
                check("idle_s1_tready", s1_tready, s1_tvalid & ~s1_tfirst);
                if ((s0_tvalid & ~s0_tfirst) | (s1_tvalid & ~s1_tfirst)) nx_orph = 1'b1;
                r0 = s0_tvalid & s0_tfirst;
                r1 = s1_tvalid & s1_tfirst;
                if (r0 | r1) begin
                    nx_owner = (r0 && r1) ? int'(!mo_last) : int'(r1);
                    nx_act   = cfg_tvalid ? cfg_modulation : mo_pend;
                end
            end else begin
                ev = (mo_owner == 1) ? s1_tvalid : s0_tvalid;
                ef = (mo_owner == 1) ? s1_tfirst : s0_tfirst;
                el = (mo_owner == 1) ? s1_tlast  : s0_tlast;
                eb = (mo_owner == 1) ? s1_bus    : s0_bus;
                et = m_tready;
                check("busy_m_src", m_src, mo_owner[0]);
                check("busy_m_tvalid", m_tvalid, ev);
                check("busy_m_tfirst", m_tfirst, ef);
                check("busy_m_tlast", m_tlast, el);
                check("busy_m_bus", m_bus, eb);
                check("busy_s0_tready", s0_tready, (mo_owner == 0) ? et : 1'b0);
                check("busy_s1_tready", s1_tready, (mo_owner == 1) ? et : 1'b0);
                if (ev && et) begin
                    olog.push_back('{m_bus, m_src, m_modulation});
                    if (el) begin
                        nx_owner = -1;
                        nx_last  = mo_owner[0];
                        if (mo_owner == 0) nx_cnt0 = mo_cnt0 + 16'd1;
                        else               nx_cnt1 = mo_cnt1 + 16'd1;
                    end
                end
            end
            if (cfg_tvalid) nx_pend = cfg_modulation;
        end
    end

    always @(posedge clk) begin
        mo_owner <= nx_owner; mo_last <= nx_last; mo_pend <= nx_pend;
        mo_act   <= nx_act;   mo_orph <= nx_orph;
        mo_cnt0  <= nx_cnt0;  mo_cnt1 <= nx_cnt1;
    end

    // ---------------- stimulus helpers ----------------
    task automatic present();
        s0_tvalid = (q0.size() != 0);
        s0_tfirst = (q0.size() != 0) ? q0[0].first : 1'b0;
        s0_tlast  = (q0.size() != 0) ? q0[0].last  : 1'b0;
        s0_bus    = (q0.size() != 0) ? q0[0].data  : '0;
        s1_tvalid = (q1.size() != 0);
        s1_tfirst = (q1.size() != 0) ? q1[0].first : 1'b0;
        s1_tlast  = (q1.size() != 0) ? q1[0].last  : 1'b0;
        s1_bus    = (q1.size() != 0) ? q1[0].data  : '0;
    endtask

    task automatic step();
        bit a0, a1;
        @(negedge clk);
        a0 = s0_tvalid && s0_tready;
        a1 = s1_tvalid && s1_tready;
        @(posedge clk);
        #1;
        if (a0) void'(q0.pop_front());
        if (a1) void'(q1.pop_front());
        if (tog) m_tready = ~m_tready;
        present();
    endtask

    task automatic push_frame(input int src, input int n, input logic [BW-1:0] base);
        for (int i = 0; i < n; i++) begin
            beat_t b;
            b.first = (i == 0);
            b.last  = (i == n - 1);
            b.data  = base + BW'(i);
            if (src == 0) q0.push_back(b);
            else          q1.push_back(b);
        end
        present();
    endtask

    task automatic run_idle(input int max, input string name);
        int  k = 0;
        bit  done = 1'b0;
        while (!done && k < max) begin
            step();
            k++;
            done = (q0.size() == 0) && (q1.size() == 0) && (mo_owner < 0);
        end
        check({name, "_drain"}, done, 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        q0.delete();
        q1.delete();
        present();
        step();
        step();
        reset = 1'b0;
        olog.delete();
    endtask

    task automatic check_obs(input string name, input int idx, input logic [BW-1:0] d,
                             input logic s, input logic [2:0] md);
        check({name, "_present"}, olog.size() > idx, 1);
        if (olog.size() > idx) begin
            check({name, "_data"}, olog[idx].data, d);
            check({name, "_src"}, olog[idx].src, s);
            check({name, "_mod"}, olog[idx].mod, md);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [BW-1:0] ed [];
        logic          es [];
        logic [2:0]    em [];
        int            k;

        reset = 1'b1; cfg_tvalid = 1'b0; cfg_modulation = 3'd0; m_tready = 1'b1;
        present();
        #1;
        check("lit_rst_m_src", m_src, 0);
        check("lit_rst_s0_tready", s0_tready, 0);
        do_reset();
        check("lit_post_rst_m_tvalid", m_tvalid, 0);

        // Single 4-beat frame from s0.
        push_frame(0, 4, 32'h8000_0010);
        run_idle(40, "t1");
        check("t1_len", olog.size(), 4);
        for (int i = 0; i < 4; i++) check_obs("t1_beat", i, 32'h8000_0010 + i, 1'b0, 3'd0);
        check("t1_idle_after", m_tvalid, 0);

        // Round-robin under contention.
        do_reset();
        push_frame(0, 2, 32'h0000_0100);
        push_frame(1, 2, 32'h0000_0200);
        run_idle(40, "t2a");
        push_frame(0, 2, 32'h0000_0300);
        push_frame(1, 2, 32'h0000_0400);
        run_idle(40, "t2b");
        push_frame(0, 2, 32'h0000_0500);
        run_idle(40, "t2c");
        push_frame(0, 2, 32'h0000_0600);
        push_frame(1, 2, 32'h0000_0700);
        run_idle(40, "t2d");
        ed = '{32'h100, 32'h101, 32'h200, 32'h201, 32'h300, 32'h301, 32'h400, 32'h401,
               32'h500, 32'h501, 32'h700, 32'h701, 32'h600, 32'h601};
        es = '{0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0};
        check("t2_len", olog.size(), 14);
        for (int i = 0; i < 14; i++) check_obs("t2_beat", i, ed[i], es[i], 3'd0);

        // Modulation latching.
        olog.delete();
        cfg_tvalid = 1'b1; cfg_modulation = 3'd3;
        step();
        cfg_tvalid = 1'b0;
        push_frame(0, 3, 32'h0000_0800);
        step();
        step();
        cfg_tvalid = 1'b1; cfg_modulation = 3'd5;
        step();
        cfg_tvalid = 1'b0;
        run_idle(40, "t3a");
        push_frame(0, 2, 32'h0000_0900);
        run_idle(40, "t3b");
        push_frame(1, 2, 32'h0000_0A00);
        cfg_tvalid = 1'b1; cfg_modulation = 3'd6;
        step();
        cfg_tvalid = 1'b0;
        run_idle(40, "t3c");
        ed = '{32'h800, 32'h801, 32'h802, 32'h900, 32'h901, 32'hA00, 32'hA01};
        es = '{0, 0, 0, 0, 0, 1, 1};
        em = '{3, 3, 3, 5, 5, 6, 6};
        check("t3_len", olog.size(), 7);
        for (int i = 0; i < 7; i++) check_obs("t3_beat", i, ed[i], es[i], em[i]);

        // Orphan beat on s1 while idle.
        do_reset();
        q1.push_back('{1'b0, 1'b0, 32'h0000_0BAD});
        present();
        #1;
        check("t4_s1_tready", s1_tready, 1);
        check("t4_m_tvalid", m_tvalid, 0);
        step();
        check("t4_consumed", q1.size(), 0);
        check("t4_err", err_orphan, 1);
        check("t4_no_out", olog.size(), 0);
        push_frame(0, 2, 32'h0000_0C00);
        run_idle(40, "t4");
        check("t4_err_sticky", err_orphan, 1);
        do_reset();
        check("t4_err_cleared", err_orphan, 0);

        // Backpressure on an s1 frame with s0 waiting.
        push_frame(1, 4, 32'h0000_0D00);
        step();
        push_frame(0, 2, 32'h0000_0E00);
        tog = 1'b1;
        run_idle(80, "t5");
        tog = 1'b0;
        m_tready = 1'b1;
        present();
        ed = '{32'hD00, 32'hD01, 32'hD02, 32'hD03, 32'hE00, 32'hE01};
        es = '{1, 1, 1, 1, 0, 0};
        check("t5_len", olog.size(), 6);
        for (int i = 0; i < 6; i++) check_obs("t5_beat", i, ed[i], es[i], 3'd0);

        // Reset in the middle of a 5-beat frame.
        do_reset();
        push_frame(0, 5, 32'h0000_0F00);
        k = 0;
        while (olog.size() < 2 && k < 20) begin
            step();
            k++;
        end
        check("t6_reached_beat2", olog.size(), 2);
        reset = 1'b1;
        #1;
        check("t6_s0_tready", s0_tready, 0);
        check("t6_s1_tready", s1_tready, 0);
        check("t6_m_tvalid", m_tvalid, 0);
`ifdef OCDM_SCHED_FRAME_CNT_EN
        check("t6_cnt0", frame_cnt0, 0);
        check("t6_cnt1", frame_cnt1, 0);
`endif
        q0.delete();
        present();
        step();
        step();
        reset = 1'b0;
        step();
        step();
        check("t6_no_more_out", olog.size(), 2);
        check("t6_idle_m_tvalid", m_tvalid, 0);

`ifdef OCDM_SCHED_FRAME_CNT_EN
        // Counter wrap after 0x10000 single-beat frames from s0.
        for (int i = 0; i < 65536; i++) begin
            push_frame(0, 1, 32'h0);
            step();
            step();
        end
        step();
        check("t7_cnt0_wrap", frame_cnt0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ocdm_frame_scheduler.md
OCDM_FRAME_SCHEDULER -- requirements
Module: ocdm_frame_scheduler

Interface
REQ-001 Parameter DATA_WIDTH, default 16, signed sample width per lane.
REQ-002 Parameter LANE, default 2, samples per beat.
REQ-003 clk  in  1  single clock; all logic rising-edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 cfg_tvalid  in  1  config write strobe; cfg_modulation  in  3  modulation code.
REQ-006 s0_tvalid/s0_tfirst/s0_tlast  in  1 each; s0_bus  in  LANE x DATA_WIDTH signed; s0_tready  out  1.
REQ-007 s1_tvalid/s1_tfirst/s1_tlast  in  1 each; s1_bus  in  LANE x DATA_WIDTH signed; s1_tready  out  1.
REQ-008 m_tvalid/m_tfirst/m_tlast  out  1 each; m_bus  out  LANE x DATA_WIDTH signed; m_tready  in  1.
REQ-009 m_modulation  out  3  modulation active for the current frame; m_src  out  1  granted source index.
REQ-010 err_orphan  out  1  sticky flag: beat arrived outside a frame.

Function
REQ-011 FSM states IDLE, BUSY; m_src holds the granted source while BUSY.
REQ-012 IDLE: m_tvalid=0; requester i requests when si_tvalid=1 and si_tfirst=1.
REQ-013 IDLE, single request: grant that source and enter BUSY next cycle.
REQ-014 IDLE, both requesting: grant the source other than the last granted (round-robin); after reset, last granted = 1, so s0 wins first.
REQ-015 IDLE: a source with si_tvalid=1 and si_tfirst=0 gets si_tready=1 for that cycle; the beat is discarded and err_orphan set.
REQ-016 BUSY: m_tvalid/m_tfirst/m_tlast/m_bus are combinational copies of the granted source; granted si_tready = m_tready; zero-cycle latency.
REQ-017 BUSY: the non-granted si_tready=0; its beats wait and are never dropped.
REQ-018 BUSY: transfer when m_tvalid and m_tready; transfer with m_tlast returns to IDLE next cycle; the last-granted register updates.
REQ-019 No arbitration in the same cycle a frame ends; the next grant is decided in IDLE, giving a minimum one-cycle gap between frames.
REQ-020 cfg_tvalid=1 loads cfg_modulation into a pending register in any state.
REQ-021 On each IDLE->BUSY transition, pending is copied to active; m_modulation = active, constant for the whole frame.
REQ-022 cfg_tvalid in the same cycle as a grant: the new cfg_modulation becomes active (bypass).
REQ-023 A mid-frame tfirst on the granted source is forwarded unchanged; it does not re-arbitrate.

Reset
REQ-024 On reset assertion, asynchronously: state=IDLE, m_src=0, last granted=1, pending=active=0, err_orphan=0.
REQ-025 During and after reset: s0_tready=s1_tready=0 and m_tvalid=0 until a new grant.
REQ-026 Reset mid-frame abandons the frame; no m_tlast is generated.

Configuration
REQ-027 Macro OCDM_SCHED_FRAME_CNT_EN defined: add outputs frame_cnt0 and frame_cnt1, 16 bits each, reset 0.
REQ-028 Each frame_cnti increments on every completed tlast transfer from source i and wraps 0xFFFF->0.
REQ-029 Macro undefined: these ports and counters do not exist; all other behaviour is identical.

Structure
REQ-030 Shared package ocdm_sched_pkg holds MODUL_WIDTH=3, the FSM state enum, and the source-index typedef.
REQ-031 Round-robin decision lives in sub-module ocdm_rr_arb2 (two requests, last-grant input, grant output); the top instantiates it once.

Verification
REQ-032 Reset, then s0 sends a 4-beat frame (tfirst on beat 0, tlast on beat 3), m_tready=1 -> 4 beats out with m_src=0; IDLE on the cycle after beat 3.
REQ-033 s0 and s1 both request after reset -> s0 frame first, then s1; repeated double requests alternate 0,1,0,1.
REQ-034 cfg 5 written mid-frame of a 3-modulation frame -> current frame keeps m_modulation=3; next frame shows 5; cfg 6 in the grant cycle -> that frame shows 6.
REQ-035 s1 beat with tvalid=1, tfirst=0 while IDLE -> s1_tready=1 one cycle, no m_tvalid, err_orphan=1 until reset.
REQ-036 m_tready toggling 1,0,1,0 during an s1 frame -> s1_tready mirrors m_tready; no beat lost or duplicated; s0 stalled throughout.
REQ-037 Reset asserted on beat 2 of 5 -> all tready=0, m_tvalid=0 immediately; with OCDM_SCHED_FRAME_CNT_EN, counters 0; 0x10000 s0 frames -> frame_cnt0 wraps to 0.
